// File: rtl/read_req_issuer.sv
// Read request issuer: walks a strided address range, keeps at most MAX_OUTSTANDING
// reads in flight, and checks that in-order responses echo their request address.
module read_req_issuer #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STRIDE          = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_tvalid,
    output logic                  cmd_tready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  req_addr_tvalid,
    input  logic                  req_addr_tready,
    output logic [ADDR_WIDTH-1:0] req_addr_tdata,
    input  logic                  bak_data_tvalid,
    output logic                  bak_data_tready,
    input  logic [DATA_WIDTH-1:0] bak_data_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_count
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  req_rem_q, req_rem_d;
    logic [LEN_WIDTH-1:0]  resp_rem_q, resp_rem_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic                  done_q, done_d;
    logic [15:0]           err_q, err_d;

    logic                  resp_active;
    logic                  req_hs;
    logic                  resp_hs;
    logic                  resp_dec;
    logic                  drop;
    logic                  mismatch;
    logic [DATA_WIDTH-1:0] exp_data;

    assign resp_active     = (resp_rem_q != '0);
    assign req_addr_tvalid = (state_q == ISSUE) && (req_rem_q != '0)
                             && (outstanding_q < OW'(MAX_OUTSTANDING));
    assign req_addr_tdata  = next_addr_q;
    assign req_hs          = req_addr_tvalid && req_addr_tready;

    // Responses pass straight through while some are still owed; otherwise they are sunk.
    assign bak_data_tready = resp_active ? out_tready : 1'b1;
    assign out_tvalid      = resp_active && bak_data_tvalid;
    assign out_tdata       = bak_data_tdata;
    assign resp_hs         = resp_active && bak_data_tvalid && out_tready;
    assign resp_dec        = resp_hs && (outstanding_q != '0);
    assign drop            = !resp_active && bak_data_tvalid;

    // Size cast zero-extends or truncates the expected address to the data width.
    assign exp_data        = DATA_WIDTH'(exp_addr_q);
    assign mismatch        = resp_hs && (bak_data_tdata != exp_data);

    assign cmd_tready      = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign err_count       = err_q;

    always_comb begin
        state_d       = state_q;
        req_rem_d     = req_rem_q;
        resp_rem_d    = resp_rem_q;
        outstanding_d = outstanding_q;
        next_addr_d   = next_addr_q;
        exp_addr_d    = exp_addr_q;
        done_d        = 1'b0;
        err_d         = err_q;

        if (req_hs) begin
            next_addr_d = next_addr_q + ADDR_WIDTH'(STRIDE);
            req_rem_d   = req_rem_q - LEN_WIDTH'(1);
        end
        if (resp_hs) begin
            exp_addr_d = exp_addr_q + ADDR_WIDTH'(STRIDE);
            resp_rem_d = resp_rem_q - LEN_WIDTH'(1);
        end
        if (req_hs && !resp_dec) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!req_hs && resp_dec) begin
            outstanding_d = outstanding_q - OW'(1);
        end
        if ((mismatch || drop) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_tvalid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        req_rem_d     = cmd_len;
                        resp_rem_d    = cmd_len;
                        outstanding_d = '0;
                        next_addr_d   = cmd_addr;
                        exp_addr_d    = cmd_addr;
                    end
                end
            end
            ISSUE, DRAIN: begin
                if (state_q == ISSUE && req_hs && req_rem_q == LEN_WIDTH'(1)) begin
                    state_d = DRAIN;
                end
                if (resp_hs && resp_rem_q == LEN_WIDTH'(1)) begin
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    req_rem_d     = '0;
                    outstanding_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            req_rem_q     <= '0;
            resp_rem_q    <= '0;
            outstanding_q <= '0;
            next_addr_q   <= '0;
            exp_addr_q    <= '0;
            done_q        <= 1'b0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            req_rem_q     <= req_rem_d;
            resp_rem_q    <= resp_rem_d;
            outstanding_q <= outstanding_d;
            next_addr_q   <= next_addr_d;
            exp_addr_q    <= exp_addr_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

endmodule
